ps2_key_sender: RTL and testbench

- Keyboard-side PS/2 transmitter: accepts one ASCII character per valid/ready handshake and maps it to a set-2 scan code.
- Emits the full keystroke as three device-to-host frames on ps2_clk/ps2_data: make code, 0xF0, make code (break).
- Drives the keyboard receiver/converter path in simulation and on board without a physical keyboard.

---
 rtl/ps2_key_sender_pkg.sv | 24 ++
 rtl/ps2_key_sender_if.sv | 9 +
 rtl/ps2_key_sender_ascii_to_scancode.sv | 43 ++++
 rtl/ps2_key_sender.sv | 133 +++++++++++++
 tb/tb_ps2_key_sender.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_sender_pkg.sv
// Shared definitions for the PS/2 keystroke sender: frame constants, FSM state
// encodings and the device-to-host frame builder.
package ps2_key_sender_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam int         FRAME_BITS = 11;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Each gap state is numerically one above the frame state it follows.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAKE = 3'd1;
    localparam logic [2:0] ST_GAP1 = 3'd2;
    localparam logic [2:0] ST_BRK  = 3'd3;
    localparam logic [2:0] ST_GAP2 = 3'd4;
    localparam logic [2:0] ST_REL  = 3'd5;
    localparam logic [2:0] ST_GAP3 = 3'd6;

    // Bit 0 is sent first: start 0, data LSB first, odd parity, stop 1.
    function automatic frame_t ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_key_sender_if.sv
// Character request handshake between a character source and ps2_key_sender.
interface ps2_key_sender_if;
    logic       ascii_valid;
    logic [7:0] ascii_data;
    logic       ascii_ready;

    modport master (output ascii_valid, output ascii_data, input ascii_ready);
    modport slave  (input ascii_valid, input ascii_data, output ascii_ready);
endinterface

// File: rtl/ps2_key_sender_ascii_to_scancode.sv
// ASCII to PS/2 set-2 make code lookup. Define PS2_SEND_LOWER_EN to also map
// 'a'..'z' onto the uppercase codes (no shift sequence is produced).
module ascii_to_scancode
    import ps2_key_sender_pkg::*;
(
    input  logic [7:0] ascii_data,
    output logic [7:0] scan,
    output logic       supported
);

    localparam logic [7:0] LETTER_SCAN [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    localparam logic [7:0] DIGIT_SCAN [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    // Upper and lower case letters both sit at offset 1..26 in their low five bits.
    logic [4:0] letter_idx;
    assign letter_idx = ascii_data[4:0] - 5'd1;

    always_comb begin
        scan      = 8'h00;
        supported = 1'b0;
        if (ascii_data >= 8'h41 && ascii_data <= 8'h5A) begin
            supported = 1'b1;
            scan      = LETTER_SCAN[letter_idx];
        end
`ifdef PS2_SEND_LOWER_EN
        else if (ascii_data >= 8'h61 && ascii_data <= 8'h7A) begin
            supported = 1'b1;
            scan      = LETTER_SCAN[letter_idx];
        end
`endif
        else if (ascii_data >= 8'h30 && ascii_data <= 8'h39) begin
            supported = 1'b1;
            scan      = DIGIT_SCAN[ascii_data[3:0]];
        end
    end

endmodule

// File: rtl/ps2_key_sender.sv
// Keyboard-side PS/2 transmitter: one ASCII character becomes make, F0, make
// frames on registered ps2_clk/ps2_data. PS2_SEND_LOWER_EN enables lowercase.
module ps2_key_sender
    import ps2_key_sender_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_sender_if.slave  bus,
    output logic             busy,
    output logic             err,
    output logic             ps2_clk,
    output logic             ps2_data
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [2:0]    state_reg;
    logic [HW-1:0] half_cnt_reg;
    logic          low_phase_reg;
    logic [3:0]    bit_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    frame_t        shift_reg;
    logic [7:0]    scan_reg;
    logic          ready_reg, busy_reg, err_reg, ps2_clk_reg, ps2_data_reg;

    logic [7:0] map_scan;
    logic       map_supported;

    ascii_to_scancode u_map (
        .ascii_data (bus.ascii_data),
        .scan       (map_scan),
        .supported  (map_supported)
    );

    assign bus.ascii_ready = ready_reg;
    assign busy            = busy_reg;
    assign err             = err_reg;
    assign ps2_clk         = ps2_clk_reg;
    assign ps2_data        = ps2_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            half_cnt_reg  <= '0;
            low_phase_reg <= 1'b0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            shift_reg     <= '1;
            scan_reg      <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            ps2_clk_reg   <= 1'b1;
            ps2_data_reg  <= 1'b1;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.ascii_valid && ready_reg) begin
                        if (map_supported) begin
                            scan_reg     <= map_scan;
                            shift_reg    <= ps2_frame(map_scan);
                            ps2_data_reg <= 1'b0;
                            half_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                            state_reg    <= ST_MAKE;
                            ready_reg    <= 1'b0;
                            busy_reg     <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_MAKE, ST_BRK, ST_REL: begin
                    if (half_cnt_reg != HALF_LAST) begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end else begin
                        half_cnt_reg <= '0;
                        if (!low_phase_reg) begin
                            low_phase_reg <= 1'b1;
                            ps2_clk_reg   <= 1'b0;
                        end else begin
                            // End of a low phase: next bit goes out with the rising edge.
                            low_phase_reg <= 1'b0;
                            ps2_clk_reg   <= 1'b1;
                            if (bit_cnt_reg == BIT_LAST) begin
                                ps2_data_reg <= 1'b1;
                                bit_cnt_reg  <= '0;
                                gap_cnt_reg  <= '0;
                                state_reg    <= state_reg + 3'd1;
                            end else begin
                                bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                                shift_reg    <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                                ps2_data_reg <= shift_reg[1];
                            end
                        end
                    end
                end
                ST_GAP1, ST_GAP2: begin
                    if (gap_cnt_reg != GAP_LAST) begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end else begin
                        shift_reg    <= ps2_frame((state_reg == ST_GAP1) ? BREAK_CODE : scan_reg);
                        ps2_data_reg <= 1'b0;
                        half_cnt_reg <= '0;
                        state_reg    <= state_reg + 3'd1;
                    end
                end
                ST_GAP3: begin
                    if (gap_cnt_reg != GAP_LAST) begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end else begin
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_IDLE;
                        ready_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_sender.sv
// Bench for ps2_key_sender: decodes the PS/2 line at every falling edge and
// compares decoded frames and timing against a table-driven keystroke model.
module tb_ps2_key_sender;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 16;
    localparam int BUSY_LEN   = 66 * CLK_DIV + 3 * GAP_CYCLES;

    localparam logic [7:0] LET_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    localparam logic [7:0] DIG_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err, ps2_clk, ps2_data;

    ps2_key_sender_if bus_if ();

    ps2_key_sender #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .busy     (busy),
        .err      (err),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Line monitor state
    logic [10:0] frames [$];
    logic [10:0] mon_cur;
    int mon_nbits, busy_cycles, err_cycles, glitch, clk_low, first_fall;
    logic prev_clk, prev_data;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_nbits = 0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (busy) busy_cycles++;
            if (err) err_cycles++;
            if (!ps2_clk) clk_low++;
            // Data may only move as the clock rises, or drop for a start bit while idle-high.
            if (ps2_data !== prev_data) begin
                if (!ps2_clk) glitch++;
                else if (prev_clk && !(prev_data && !ps2_data)) glitch++;
            end
            if (prev_clk && !ps2_clk) begin
                if (frames.size() == 0 && mon_nbits == 0 && first_fall == 0)
                    first_fall = busy_cycles;
                mon_cur[mon_nbits] = ps2_data;
                mon_nbits++;
                if (mon_nbits == 11) begin
                    frames.push_back(mon_cur);
                    mon_nbits = 0;
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit model_lookup(input logic [7:0] c, output logic [7:0] s);
        string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        s = 8'h00;
        for (int i = 0; i < 26; i++) begin
            if (c == letters[i]) begin
                s = LET_CODES[i];
                return 1'b1;
            end
`ifdef PS2_SEND_LOWER_EN
            if (c == 8'(letters[i] + 32)) begin
                s = LET_CODES[i];
                return 1'b1;
            end
`endif
        end
        for (int i = 0; i < 10; i++) begin
            if (c == 8'(8'h30 + i)) begin
                s = DIG_CODES[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit framing_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
    endfunction

    task automatic check_frames(input logic [7:0] exp_bytes [$]);
        check("frame_count", frames.size(), exp_bytes.size());
        for (int i = 0; i < frames.size() && i < exp_bytes.size(); i++) begin
            check("frame_data", {24'd0, frames[i][8:1]}, {24'd0, exp_bytes[i]});
            check("frame_format", {31'd0, framing_ok(frames[i])}, 32'd1);
        end
    endtask

    task automatic clear_monitor();
        frames.delete();
        busy_cycles = 0;
        err_cycles  = 0;
        glitch      = 0;
        clk_low     = 0;
        first_fall  = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus_if.ascii_ready && n < 4000) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus_if.ascii_ready}, 32'd1);
    endtask

    task automatic send_char(input logic [7:0] c);
        logic [7:0] s;
        logic [7:0] exp_q [$];
        bit sup;
        sup = model_lookup(c, s);
        wait_ready("ready_before_send");
        clear_monitor();
        bus_if.ascii_valid = 1'b1;
        bus_if.ascii_data  = c;
        tick();
        bus_if.ascii_valid = 1'b0;
        bus_if.ascii_data  = 8'($urandom);
        check("err_after_accept", {31'd0, err}, {31'd0, !sup});
        check("busy_after_accept", {31'd0, busy}, {31'd0, sup});
        check("ready_after_accept", {31'd0, bus_if.ascii_ready}, {31'd0, !sup});
        if (sup) begin
            check("start_bit_data", {31'd0, ps2_data}, 32'd0);
            check("start_bit_clk", {31'd0, ps2_clk}, 32'd1);
            wait_ready("ready_after_char");
            check("busy_cycles", busy_cycles, BUSY_LEN);
            check("first_fall_delay", first_fall, CLK_DIV + 1);
            exp_q = '{s, 8'hF0, s};
            check_frames(exp_q);
        end else begin
            tick();
            check("err_width", {31'd0, err}, 32'd0);
            repeat (20) tick();
            check("unsup_frames", frames.size(), 0);
            check("unsup_clk_low", clk_low, 0);
            check("unsup_data_high", {31'd0, ps2_data}, 32'd1);
            check("unsup_ready", {31'd0, bus_if.ascii_ready}, 32'd1);
        end
        check("err_cycles", err_cycles, sup ? 0 : 1);
        check("data_timing", glitch, 0);
        $display("char %02h sup=%0d frames=%0d busy=%0d err=%0d", c, sup, frames.size(), busy_cycles, err_cycles);
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] c;
        int n;

        bus_if.ascii_valid = 1'b0;
        bus_if.ascii_data  = 8'h00;
        clear_monitor();
        repeat (3) tick();
        check("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
        check("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
        check("rst_ready", {31'd0, bus_if.ascii_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 'A': exact bit patterns of make and break frames
        send_char(8'h41);
        if (frames.size() == 3) begin
            check("A_make_bits", {21'd0, frames[0]}, 32'h438);
            check("A_break_bits", {21'd0, frames[1]}, 32'h7E0);
            check("A_release_bits", {21'd0, frames[2]}, 32'h438);
        end else begin
            check("A_frame_total", frames.size(), 3);
        end

        send_char(8'h39);   // '9'
        send_char(8'h23);   // '#'
        send_char(8'h71);   // 'q'

        // Random characters: letters, digits and arbitrary bytes
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    c = 8'h41 + 8'($urandom_range(0, 25));
                2:       c = 8'h30 + 8'($urandom_range(0, 9));
                default: c = 8'($urandom_range(0, 255));
            endcase
            send_char(c);
        end

        // 'B' then 'C' with valid held high throughout
        wait_ready("b2b_ready");
        clear_monitor();
        bus_if.ascii_valid = 1'b1;
        bus_if.ascii_data  = 8'h42;
        tick();
        bus_if.ascii_data = 8'h43;
        check("b2b_first_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!bus_if.ascii_ready && n < 4000) begin
            tick();
            n++;
        end
        check("b2b_ready_delay", n, BUSY_LEN);
        tick();
        bus_if.ascii_valid = 1'b0;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        check("b2b_second_ready", {31'd0, bus_if.ascii_ready}, 32'd0);
        wait_ready("b2b_done");
        check("b2b_busy_cycles", busy_cycles, 2 * BUSY_LEN);
        exp_q = '{8'h32, 8'hF0, 8'h32, 8'h21, 8'hF0, 8'h21};
        check_frames(exp_q);
        check("b2b_data_timing", glitch, 0);
        $display("b2b frames=%0d busy=%0d", frames.size(), busy_cycles);

        // Reset in the middle of bit 5 of the break frame
        clear_monitor();
        bus_if.ascii_valid = 1'b1;
        bus_if.ascii_data  = 8'h4D;
        tick();
        bus_if.ascii_valid = 1'b0;
        n = 0;
        while (!(frames.size() == 1 && mon_nbits == 6) && n < 4000) begin
            tick();
            n++;
        end
        check("reach_brk_bit5", {31'd0, (frames.size() == 1 && mon_nbits == 6)}, 32'd1);
        check("pre_rst_clk_low", {31'd0, ps2_clk}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("midrst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
        check("midrst_ps2_data", {31'd0, ps2_data}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, bus_if.ascii_ready}, 32'd1);
        $display("reset mid-break clk=%0d data=%0d busy=%0d", ps2_clk, ps2_data, busy);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        send_char(8'h5A);   // 'Z'

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
